// File: rtl/ctr_lfsr.sv
// Fibonacci XNOR LFSR counter, 3..16 bits, optional 2^WIDTH period, terminal-count auto-reload.
// out/tc registered (one-edge latency); no backpressure, every inc edge advances or reloads.
module ctr_lfsr #(
  parameter int               WIDTH   = 8,
  parameter int               FULL    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             tc_en,
  input  logic [WIDTH-1:0] tc_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("ctr_lfsr: WIDTH must be 3..16");
  end
  if (FULL != 0 && FULL != 1) begin : g_bad_full
    $error("ctr_lfsr: FULL must be 0 or 1");
  end
  if (FULL == 0 && RST_VAL == {WIDTH{1'b1}}) begin : g_bad_rst
    $error("ctr_lfsr: all-ones RST_VAL is a lock-up state when FULL=0");
  end

  // Bit k of the tap list sits at out[k-1].
  function automatic logic [WIDTH-1:0] tap_mask();
    logic [15:0]      m16;
    logic [WIDTH-1:0] m;
    case (WIDTH)
      3:       m16 = 16'h0006;
      4:       m16 = 16'h000C;
      5:       m16 = 16'h0014;
      6:       m16 = 16'h0030;
      7:       m16 = 16'h0060;
      8:       m16 = 16'h00B8;
      9:       m16 = 16'h0110;
      10:      m16 = 16'h0240;
      11:      m16 = 16'h0500;
      12:      m16 = 16'h0829;
      13:      m16 = 16'h100D;
      14:      m16 = 16'h2015;
      15:      m16 = 16'h6000;
      16:      m16 = 16'hD008;
      default: m16 = 16'h0000;
    endcase
    m = '0;
    for (int i = 0; i < WIDTH && i < 16; i++) m[i] = m16[i];
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAPS = tap_mask();

  logic             fb;
  logic [WIDTH-1:0] nxt;
  logic             hit;

  // In full-period mode the feedback flips when the low bits are all ones,
  // splicing 1..1 in between 01..1 and 1..10.
  always_comb begin
    fb = ~^(out & TAPS);
    if (FULL != 0 && (&out[WIDTH-2:0])) fb = ~fb;
    nxt = {out[WIDTH-2:0], fb};
  end

  assign hit = inc && tc_en && (out == tc_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RST_VAL;
      tc  <= 1'b0;
    end else if (load) begin
      out <= seed;
      tc  <= 1'b0;
    end else if (hit) begin
      out <= seed;
      tc  <= 1'b1;
    end else if (inc) begin
      out <= nxt;
      tc  <= 1'b0;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctr_lfsr.sv
// Bench for ctr_lfsr: 4-bit vector table, corner sequences, randomized model check, per-width period sweep.
module tb_ctr_lfsr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0, load = 1'b0, tc_en = 1'b0;
  logic [3:0] seed = '0, tc_val = '0;
  logic [3:0] out_a, out_b;
  logic       tc_a, tc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctr_lfsr #(.WIDTH(4), .FULL(0), .RST_VAL(4'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(load), .seed(seed),
    .tc_en(tc_en), .tc_val(tc_val), .out(out_a), .tc(tc_a));

  ctr_lfsr #(.WIDTH(4), .FULL(1), .RST_VAL(4'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(load), .seed(seed),
    .tc_en(tc_en), .tc_val(tc_val), .out(out_b), .tc(tc_b));

  // State orders for WIDTH=4 as listed for the two period modes.
  logic [3:0] seq0 [0:14];
  logic [3:0] seq1 [0:15];

  function automatic logic [3:0] m_adv(input logic [3:0] s, input bit full);
    if (full) begin
      for (int i = 0; i < 16; i++) if (seq1[i] == s) return seq1[(i + 1) % 16];
    end else begin
      if (s == 4'hF) return 4'hF;
      for (int i = 0; i < 15; i++) if (seq0[i] == s) return seq0[(i + 1) % 15];
    end
    return 4'hx;
  endfunction

  // Returns {tc, next state}.
  function automatic logic [4:0] m_step(input logic [3:0] s, input bit full, input bit ld,
                                        input bit in, input bit te, input logic [3:0] sd,
                                        input logic [3:0] tv);
    if (ld) return {1'b0, sd};
    if (in && te && s == tv) return {1'b1, sd};
    if (in) return {1'b0, m_adv(s, full)};
    return {1'b0, s};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         ld;
    bit         in;
    logic [3:0] sd;
    bit         te;
    logic [3:0] tv;
    logic [3:0] ea;
    bit         eta;
    logic [3:0] eb;
    bit         etb;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  // Per-width period sweep: one instance per (WIDTH, FULL) pair.
  localparam int NP = 28;
  logic        per_rst_n = 1'b0;
  logic        per_inc = 1'b0;
  logic        per_run = 1'b0;
  logic [31:0] period_w [0:NP-1];
  logic        dup_w    [0:NP-1];

  for (genvar gi = 0; gi < NP; gi++) begin : g_per
    localparam int W = 3 + gi / 2;
    localparam int F = gi % 2;
    localparam logic [W-1:0] RV = W'(gi % 3);
    logic [W-1:0] o;
    logic         t;
    int           cnt = 0;
    int           period = 0;
    bit           dup = 1'b0;
    bit           seen [0:(1<<W)-1];

    ctr_lfsr #(.WIDTH(W), .FULL(F), .RST_VAL(RV)) u_p (
      .clk(clk), .rst_n(per_rst_n), .inc(per_inc), .load(1'b0), .seed(RV),
      .tc_en(1'b0), .tc_val(RV), .out(o), .tc(t));

    always @(negedge clk) begin
      if (per_run) begin
        cnt++;
        if (period == 0) begin
          if (o == RV) period = cnt;
          else begin
            if (seen[o]) dup = 1'b1;
            seen[o] = 1'b1;
          end
        end
      end
    end

    assign period_w[gi] = period;
    assign dup_w[gi]    = dup;
  end

  initial begin
    logic [3:0] ma, mb;
    logic       mta, mtb;
    logic [4:0] r;

    seq0 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    seq1 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

    //          ld in sd    te tv     ea  eta eb  etb
    vt[0]  = '{0, 1, 4'h0, 0, 4'h0, 4'h1, 0, 4'h1, 0};
    vt[1]  = '{0, 1, 4'h0, 0, 4'h0, 4'h3, 0, 4'h3, 0};
    vt[2]  = '{0, 1, 4'h0, 0, 4'h0, 4'h7, 0, 4'h7, 0};
    vt[3]  = '{0, 1, 4'h0, 0, 4'h0, 4'hE, 0, 4'hF, 0};
    vt[4]  = '{0, 1, 4'h0, 0, 4'h0, 4'hD, 0, 4'hE, 0};
    vt[5]  = '{0, 1, 4'h0, 0, 4'h0, 4'hB, 0, 4'hD, 0};
    vt[6]  = '{0, 0, 4'h0, 0, 4'h0, 4'hB, 0, 4'hD, 0};
    vt[7]  = '{1, 1, 4'h3, 0, 4'h0, 4'h3, 0, 4'h3, 0};
    vt[8]  = '{1, 1, 4'h9, 0, 4'h0, 4'h9, 0, 4'h9, 0};
    vt[9]  = '{0, 1, 4'h0, 0, 4'h0, 4'h2, 0, 4'h2, 0};
    vt[10] = '{1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0, 0};
    vt[11] = '{0, 1, 4'h0, 1, 4'h7, 4'h1, 0, 4'h1, 0};
    vt[12] = '{0, 1, 4'h0, 1, 4'h7, 4'h3, 0, 4'h3, 0};
    vt[13] = '{0, 1, 4'h0, 1, 4'h7, 4'h7, 0, 4'h7, 0};
    vt[14] = '{0, 1, 4'h0, 1, 4'h7, 4'h0, 1, 4'h0, 1};
    vt[15] = '{0, 1, 4'h0, 1, 4'h7, 4'h1, 0, 4'h1, 0};
    vt[16] = '{1, 0, 4'h5, 0, 4'h0, 4'h5, 0, 4'h5, 0};
    vt[17] = '{0, 1, 4'h5, 1, 4'h5, 4'h5, 1, 4'h5, 1};
    vt[18] = '{0, 1, 4'h5, 1, 4'h5, 4'h5, 1, 4'h5, 1};
    vt[19] = '{0, 0, 4'h5, 1, 4'h5, 4'h5, 0, 4'h5, 0};
    vt[20] = '{0, 1, 4'h5, 1, 4'hF, 4'hA, 0, 4'hA, 0};
    vt[21] = '{1, 1, 4'hF, 0, 4'h0, 4'hF, 0, 4'hF, 0};
    vt[22] = '{0, 1, 4'h0, 0, 4'h0, 4'hF, 0, 4'hE, 0};
    vt[23] = '{0, 1, 4'h0, 0, 4'h0, 4'hF, 0, 4'hD, 0};
    vt[24] = '{1, 1, 4'h3, 1, 4'hD, 4'h3, 0, 4'h3, 0};

    #1;
    chk("reset out_a", out_a, 4'h0);
    chk("reset tc_a", tc_a, 1'b0);
    chk("reset out_b", out_b, 4'h0);
    chk("reset tc_b", tc_b, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      load = vt[i].ld; inc = vt[i].in; seed = vt[i].sd; tc_en = vt[i].te; tc_val = vt[i].tv;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_a", i), out_a, vt[i].ea);
      chk($sformatf("vec%0d tc_a", i), tc_a, vt[i].eta);
      chk($sformatf("vec%0d out_b", i), out_b, vt[i].eb);
      chk($sformatf("vec%0d tc_b", i), tc_b, vt[i].etb);
    end

    // Lock-up: all-ones seed with FULL=0 never leaves all-ones.
    load = 1'b1; seed = 4'hF; inc = 1'b1; tc_en = 1'b0;
    @(posedge clk); #1;
    chk("lock load out_a", out_a, 4'hF);
    load = 1'b0;
    mb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      mb = m_adv(mb, 1'b1);
      chk("lock out_a", out_a, 4'hF);
      chk("lock out_b", out_b, mb);
    end

    // Async reset lands between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("async rst out_a", out_a, 4'h0);
    chk("async rst out_b", out_b, 4'h0);
    chk("async rst tc_a", tc_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clears a pending tc pulse.
    tc_en = 1'b1; tc_val = 4'h0; seed = 4'h3; inc = 1'b1;
    @(posedge clk); #1;
    chk("reload out_a", out_a, 4'h3);
    chk("reload tc_a", tc_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst clears tc_a", tc_a, 1'b0);
    chk("rst clears tc_b", tc_b, 1'b0);
    chk("rst mid out_a", out_a, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the behavioural model.
    ma = 4'h0; mb = 4'h0; mta = 1'b0; mtb = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      load   = ($urandom_range(0, 9) == 0);
      inc    = ($urandom_range(0, 3) != 0);
      tc_en  = $urandom_range(0, 1);
      seed   = 4'($urandom_range(0, 15));
      tc_val = ($urandom_range(0, 3) == 0) ? ma : 4'($urandom_range(0, 15));
      @(posedge clk);
      r = m_step(ma, 1'b0, load, inc, tc_en, seed, tc_val); ma = r[3:0]; mta = r[4];
      r = m_step(mb, 1'b1, load, inc, tc_en, seed, tc_val); mb = r[3:0]; mtb = r[4];
      #1;
      chk("rand a", {tc_a, out_a}, {mta, ma});
      chk("rand b", {tc_b, out_b}, {mtb, mb});
    end
    load = 1'b0; inc = 1'b0; tc_en = 1'b0;

    // Period sweep for every width and both modes.
    @(negedge clk);
    per_rst_n = 1'b1;
    @(negedge clk);
    per_inc = 1'b1;
    @(posedge clk); #1;
    per_run = 1'b1;
    repeat (65540) @(negedge clk);
    #1 per_run = 1'b0;
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("period w%0d full%0d", 3 + i / 2, i % 2), period_w[i],
          (32'd1 << (3 + i / 2)) - 32'd1 + 32'(i % 2));
      chk($sformatf("no repeat w%0d full%0d", 3 + i / 2, i % 2), 32'(dup_w[i]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
